// File: rtl/cr_axi_wr_port_bridge.sv
// cr_axi_wr_port_bridge: per-port AXI write bridge. AW, W and B each pass through a 2-entry skid buffer.
// Latency: 1 cycle on every channel. Backpressure: input readys are registered (no comb path from output ready).
//   AW ready also drops once the outstanding writes (counted + held in the AW skid) reach MAX_OUTSTANDING.
// Ports: clk/rst_n; s_aw*/s_w*/s_b* upstream; m_aw*/m_w*/m_b* downstream (port 0 in the LSBs of each field);
//   out_cnt = live outstanding count per port; err_unexp_b = sticky "B with count 0" flag, cleared by err_clr.

// Two-entry FIFO-ordered skid buffer with a registered input ready.
// Ports: in_* push side, out_* pop side; ext_cnt_i is the next-cycle external count
//   checked against LIMIT (LIMIT = 0 disables the limit).
module cr_axi_wr_port_bridge_skid #(
  parameter int W     = 8,
  parameter int CW    = 4,
  parameter int LIMIT = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CW-1:0] ext_cnt_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [W-1:0]  in_data_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [W-1:0]  out_data_o
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

  localparam int TW = CW + 2;

  state_e       state_q, state_d;
  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q, rd_ptr_q;
  logic         rdy_q, rdy_d;
  logic         push, pop;
  logic [1:0]   occ_d;
  logic         hold;

  assign push        = in_valid_i && rdy_q;
  assign pop         = (state_q != EMPTY) && out_ready_i;
  assign out_valid_o = (state_q != EMPTY);
  assign out_data_o  = mem_q[rd_ptr_q];
  assign in_ready_o  = rdy_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (push) state_d = ONE;
      ONE: begin
        if (push && !pop)      state_d = TWO;
        else if (!push && pop) state_d = EMPTY;
      end
      TWO:     if (pop) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    occ_d = 2'd0;
    case (state_d)
      ONE:     occ_d = 2'd1;
      TWO:     occ_d = 2'd2;
      default: occ_d = 2'd0;
    endcase
  end

  // Ready for next cycle looks at next-cycle occupancy plus next-cycle external count,
  // so an accepted beat can never push the total past LIMIT.
  assign hold  = (LIMIT != 0) && ((TW'(ext_cnt_i) + TW'(occ_d)) >= TW'(LIMIT));
  assign rdy_d = (state_d != TWO) && !hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      rdy_q    <= 1'b0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
      if (push) begin
        mem_q[wr_ptr_q] <= in_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
    end
  end
endmodule

module cr_axi_wr_port_bridge #(
  parameter int NUM_PORTS       = 2,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 64,
  parameter int ID_W            = 4,
  parameter int MAX_OUTSTANDING = 8,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_PORTS-1:0]            s_awvalid,
  output logic [NUM_PORTS-1:0]            s_awready,
  input  logic [NUM_PORTS*ADDR_W-1:0]     s_awaddr,
  input  logic [NUM_PORTS*ID_W-1:0]       s_awid,
  input  logic [NUM_PORTS-1:0]            s_wvalid,
  output logic [NUM_PORTS-1:0]            s_wready,
  input  logic [NUM_PORTS*DATA_W-1:0]     s_wdata,
  input  logic [NUM_PORTS*DATA_W/8-1:0]   s_wstrb,
  input  logic [NUM_PORTS-1:0]            s_wlast,
  output logic [NUM_PORTS-1:0]            s_bvalid,
  input  logic [NUM_PORTS-1:0]            s_bready,
  output logic [NUM_PORTS*ID_W-1:0]       s_bid,
  output logic [NUM_PORTS*2-1:0]          s_bresp,
  output logic [NUM_PORTS-1:0]            m_awvalid,
  input  logic [NUM_PORTS-1:0]            m_awready,
  output logic [NUM_PORTS*ADDR_W-1:0]     m_awaddr,
  output logic [NUM_PORTS*ID_W-1:0]       m_awid,
  output logic [NUM_PORTS-1:0]            m_wvalid,
  input  logic [NUM_PORTS-1:0]            m_wready,
  output logic [NUM_PORTS*DATA_W-1:0]     m_wdata,
  output logic [NUM_PORTS*DATA_W/8-1:0]   m_wstrb,
  output logic [NUM_PORTS-1:0]            m_wlast,
  input  logic [NUM_PORTS-1:0]            m_bvalid,
  output logic [NUM_PORTS-1:0]            m_bready,
  input  logic [NUM_PORTS*ID_W-1:0]       m_bid,
  input  logic [NUM_PORTS*2-1:0]          m_bresp,
  output logic [NUM_PORTS*CNT_W-1:0]      out_cnt,
  output logic [NUM_PORTS-1:0]            err_unexp_b,
  input  logic [NUM_PORTS-1:0]            err_clr
);
  localparam int STRB_W = DATA_W / 8;
  localparam int AWP_W  = ADDR_W + ID_W;
  localparam int WP_W   = DATA_W + STRB_W + 1;
  localparam int BP_W   = ID_W + 2;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [AWP_W-1:0] aw_in, aw_out;
    logic [WP_W-1:0]  w_in, w_out;
    logic [BP_W-1:0]  b_in, b_out;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             aw_hs, b_hs;

    assign aw_in = {s_awid[p*ID_W +: ID_W], s_awaddr[p*ADDR_W +: ADDR_W]};
    assign w_in  = {s_wlast[p], s_wstrb[p*STRB_W +: STRB_W], s_wdata[p*DATA_W +: DATA_W]};
    assign b_in  = {m_bid[p*ID_W +: ID_W], m_bresp[p*2 +: 2]};

    cr_axi_wr_port_bridge_skid #(.W(AWP_W), .CW(CNT_W), .LIMIT(MAX_OUTSTANDING)) u_aw (
      .clk(clk), .rst_n(rst_n), .ext_cnt_i(cnt_d),
      .in_valid_i(s_awvalid[p]), .in_ready_o(s_awready[p]), .in_data_i(aw_in),
      .out_valid_o(m_awvalid[p]), .out_ready_i(m_awready[p]), .out_data_o(aw_out));

    // W is deliberately not tied to the AW count.
    cr_axi_wr_port_bridge_skid #(.W(WP_W), .CW(CNT_W), .LIMIT(0)) u_w (
      .clk(clk), .rst_n(rst_n), .ext_cnt_i('0),
      .in_valid_i(s_wvalid[p]), .in_ready_o(s_wready[p]), .in_data_i(w_in),
      .out_valid_o(m_wvalid[p]), .out_ready_i(m_wready[p]), .out_data_o(w_out));

    cr_axi_wr_port_bridge_skid #(.W(BP_W), .CW(CNT_W), .LIMIT(0)) u_b (
      .clk(clk), .rst_n(rst_n), .ext_cnt_i('0),
      .in_valid_i(m_bvalid[p]), .in_ready_o(m_bready[p]), .in_data_i(b_in),
      .out_valid_o(s_bvalid[p]), .out_ready_i(s_bready[p]), .out_data_o(b_out));

    assign m_awaddr[p*ADDR_W +: ADDR_W] = aw_out[ADDR_W-1:0];
    assign m_awid[p*ID_W +: ID_W]       = aw_out[AWP_W-1:ADDR_W];
    assign m_wdata[p*DATA_W +: DATA_W]  = w_out[DATA_W-1:0];
    assign m_wstrb[p*STRB_W +: STRB_W]  = w_out[DATA_W +: STRB_W];
    assign m_wlast[p]                   = w_out[WP_W-1];
    assign s_bresp[p*2 +: 2]            = b_out[1:0];
    assign s_bid[p*ID_W +: ID_W]        = b_out[BP_W-1:2];

    assign aw_hs = m_awvalid[p] && m_awready[p];
    assign b_hs  = m_bvalid[p] && m_bready[p];

    // A B with nothing outstanding is still forwarded; the count saturates at 0 and the error latches.
    always_comb begin
      cnt_d = cnt_q;
      err_d = err_q;
      if (aw_hs && !b_hs)                       cnt_d = cnt_q + CNT_W'(1);
      else if (!aw_hs && b_hs && cnt_q != '0)   cnt_d = cnt_q - CNT_W'(1);
      if (err_clr[p])                           err_d = 1'b0;
      if (b_hs && cnt_q == '0)                  err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
        err_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        err_q <= err_d;
      end
    end

    assign out_cnt[p*CNT_W +: CNT_W] = cnt_q;
    assign err_unexp_b[p]            = err_q;
  end
endmodule

// File: tb/tb_cr_axi_wr_port_bridge.sv
module tb_cr_axi_wr_port_bridge;
  localparam int NP = 2, AW = 32, DW = 64, IW = 4, MO = 8, CW = 4, SW = DW / 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NP-1:0]     s_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready;
  logic [NP*AW-1:0]  s_awaddr, m_awaddr;
  logic [NP*IW-1:0]  s_awid, m_awid, s_bid, m_bid;
  logic [NP*DW-1:0]  s_wdata, m_wdata;
  logic [NP*SW-1:0]  s_wstrb, m_wstrb;
  logic [NP*2-1:0]   s_bresp, m_bresp;
  logic [NP-1:0]     m_awvalid, m_awready, m_wvalid, m_wready, m_wlast, m_bvalid, m_bready;
  logic [NP*CW-1:0]  out_cnt;
  logic [NP-1:0]     err_unexp_b, err_clr;

  int n_chk = 0;
  int n_fail = 0;

  cr_axi_wr_port_bridge #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .MAX_OUTSTANDING(MO)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awid(s_awid),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_bresp(s_bresp),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awid(m_awid),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(m_bid), .m_bresp(m_bresp),
    .out_cnt(out_cnt), .err_unexp_b(err_unexp_b), .err_clr(err_clr));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [DW-1:0] bd [3];
  logic [SW-1:0] bs [3];
  logic          bl [3];

  initial begin
    int acc;
    int ok;

    bd[0] = 64'h1111_2222_3333_4444; bs[0] = 8'h0F; bl[0] = 1'b0;
    bd[1] = 64'hAAAA_BBBB_CCCC_DDDD; bs[1] = 8'hF0; bl[1] = 1'b0;
    bd[2] = 64'hDEAD_BEEF_0123_4567; bs[2] = 8'hFF; bl[2] = 1'b1;

    rst_n = 1'b0;
    s_awvalid = '0; s_awaddr = '0; s_awid = '0;
    s_wvalid = '0; s_wdata = '0; s_wstrb = '0; s_wlast = '0;
    s_bready = '1;
    m_awready = '1; m_wready = '1;
    m_bvalid = '0; m_bid = '0; m_bresp = '0;
    err_clr = '0;

    // Reset state
    tick(2);
    chk("rst_s_awready", s_awready, 0);
    chk("rst_m_bready", m_bready, 0);
    chk("rst_m_awvalid", m_awvalid, 0);
    chk("rst_out_cnt", out_cnt, 0);
    chk("rst_err", err_unexp_b, 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_awready", s_awready, 2'b11);
    chk("post_rst_wready", s_wready, 2'b11);
    chk("post_rst_bready", m_bready, 2'b11);

    // Single AW, 1-cycle latency
    s_awvalid[0] = 1'b1; s_awaddr[31:0] = 32'h1000; s_awid[3:0] = 4'd3;
    chk("aw_not_yet", m_awvalid[0], 0);
    tick();
    s_awvalid[0] = 1'b0;
    chk("aw_valid_lat1", m_awvalid[0], 1);
    chk("aw_addr", m_awaddr[31:0], 32'h1000);
    chk("aw_id", m_awid[3:0], 3);
    chk("aw_port1_idle", m_awvalid[1], 0);
    tick();
    chk("aw_cnt1", out_cnt[3:0], 1);
    chk("aw_drained", m_awvalid[0], 0);

    // Matching B returns count to 0, forwarded unmodified
    m_bvalid[0] = 1'b1; m_bid[3:0] = 4'd3; m_bresp[1:0] = 2'b01;
    tick();
    m_bvalid[0] = 1'b0;
    chk("b_cnt0", out_cnt[3:0], 0);
    chk("b_fwd_valid", s_bvalid[0], 1);
    chk("b_fwd_id", s_bid[3:0], 3);
    chk("b_fwd_resp", s_bresp[1:0], 2'b01);
    chk("b_no_err", err_unexp_b[0], 0);
    tick();
    chk("b_drained", s_bvalid[0], 0);

    // Outstanding limit
    acc = 0;
    s_awvalid[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (s_awready[0]) acc++;
      tick();
    end
    s_awvalid[0] = 1'b0;
    chk("lim_accepted", acc, 8);
    chk("lim_cnt8", out_cnt[3:0], 8);
    chk("lim_awready0", s_awready[0], 0);
    m_bvalid[0] = 1'b1;
    tick();
    m_bvalid[0] = 1'b0;
    chk("lim_cnt7", out_cnt[3:0], 7);
    ok = 0;
    for (int i = 0; i < 2; i++) begin
      if (s_awready[0]) ok = 1;
      if (ok == 0) tick();
    end
    chk("lim_awready_back", ok, 1);
    m_bvalid[0] = 1'b1;
    tick(7);
    m_bvalid[0] = 1'b0;
    chk("lim_drain_cnt0", out_cnt[3:0], 0);
    chk("lim_no_err", err_unexp_b[0], 0);
    tick(2);

    // Simultaneous AW and B handshakes at count 5
    s_awvalid[0] = 1'b1;
    tick(5);
    s_awvalid[0] = 1'b0;
    tick(2);
    chk("sim_cnt5", out_cnt[3:0], 5);
    m_awready[0] = 1'b0;
    s_awvalid[0] = 1'b1;
    tick();
    s_awvalid[0] = 1'b0;
    tick();
    chk("sim_aw_held", m_awvalid[0], 1);
    chk("sim_cnt5_held", out_cnt[3:0], 5);
    m_awready[0] = 1'b1; m_bvalid[0] = 1'b1;
    tick();
    m_bvalid[0] = 1'b0;
    chk("sim_cnt_same", out_cnt[3:0], 5);
    chk("sim_aw_gone", m_awvalid[0], 0);
    m_bvalid[0] = 1'b1;
    tick(5);
    m_bvalid[0] = 1'b0;
    chk("sim_cnt_zero", out_cnt[3:0], 0);
    tick(2);

    // W stall: two beats buffered, third blocked, then in-order release
    m_wready[0] = 1'b0;
    s_wvalid[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      s_wdata[63:0] = bd[k]; s_wstrb[7:0] = bs[k]; s_wlast[0] = bl[k];
      if (k < 2) tick();
    end
    chk("w_full_rdy0", s_wready[0], 0);
    tick();
    chk("w_full_rdy0_b", s_wready[0], 0);
    chk("w_head_data0", m_wdata[63:0], bd[0]);
    chk("w_head_vld", m_wvalid[0], 1);
    m_wready[0] = 1'b1;
    tick();
    chk("w_beat1_data", m_wdata[63:0], bd[1]);
    chk("w_beat1_strb", m_wstrb[7:0], bs[1]);
    chk("w_beat1_last", m_wlast[0], 0);
    chk("w_rdy_back", s_wready[0], 1);
    tick();
    s_wvalid[0] = 1'b0;
    chk("w_beat2_data", m_wdata[63:0], bd[2]);
    chk("w_beat2_strb", m_wstrb[7:0], bs[2]);
    chk("w_beat2_last", m_wlast[0], 1);
    tick();
    chk("w_empty", m_wvalid[0], 0);
    chk("w_no_cnt", out_cnt[3:0], 0);

    // Unexpected B on port 1
    m_bvalid[1] = 1'b1; m_bid[7:4] = 4'd5; m_bresp[3:2] = 2'b10;
    tick();
    m_bvalid[1] = 1'b0;
    chk("ub_fwd_valid", s_bvalid[1], 1);
    chk("ub_fwd_id", s_bid[7:4], 5);
    chk("ub_fwd_resp", s_bresp[3:2], 2'b10);
    chk("ub_cnt1_zero", out_cnt[7:4], 0);
    chk("ub_err1", err_unexp_b[1], 1);
    chk("ub_err0", err_unexp_b[0], 0);
    tick(2);
    chk("ub_err1_held", err_unexp_b[1], 1);
    err_clr[1] = 1'b1;
    tick();
    err_clr[1] = 1'b0;
    chk("ub_err1_clr", err_unexp_b[1], 0);
    m_bvalid[1] = 1'b1; err_clr[1] = 1'b1;
    tick();
    m_bvalid[1] = 1'b0; err_clr[1] = 1'b0;
    chk("ub_set_wins", err_unexp_b[1], 1);
    err_clr[1] = 1'b1;
    tick();
    err_clr[1] = 1'b0;
    chk("ub_err1_clr2", err_unexp_b[1], 0);
    chk("ub_err0_end", err_unexp_b[0], 0);
    tick();

    // Reset mid-transfer
    s_awvalid[0] = 1'b1;
    tick();
    s_awvalid[0] = 1'b0;
    tick();
    chk("mr_cnt1", out_cnt[3:0], 1);
    m_wready[0] = 1'b0;
    s_wvalid[0] = 1'b1; s_wdata[63:0] = bd[0];
    tick(2);
    s_wvalid[0] = 1'b0;
    chk("mr_w_buffered", m_wvalid[0], 1);
    rst_n = 1'b0;
    #1;
    chk("mr_wvalid0", m_wvalid[0], 0);
    chk("mr_cnt0", out_cnt, 0);
    chk("mr_wready0", s_wready, 0);
    m_wready[0] = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    chk("mr_rdy_back", s_wready, 2'b11);
    ok = 0;
    for (int i = 0; i < 4; i++) begin
      if (m_wvalid[0]) ok = 1;
      tick();
    end
    chk("mr_no_stale", ok, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cr_axi_wr_port_bridge.md
CR_AXI_WR_PORT_BRIDGE -- requirements
Module: cr_axi_wr_port_bridge

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2, number of independent AXI write ports (1..16).
REQ-002 SHALL have parameter ADDR_W, default 32, AW address width.
REQ-003 SHALL have parameter DATA_W, default 64, W data width; strobe width is DATA_W/8.
REQ-004 SHALL have parameter ID_W, default 4, AW/B ID width.
REQ-005 SHALL have parameter MAX_OUTSTANDING, default 8, per-port write limit (1..255); CNT_W = clog2(MAX_OUTSTANDING+1).
REQ-006 SHALL have ports, with per-port fields packed with port 0 in the LSBs:
- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_awvalid/s_awready  in/out  NUM_PORTS  upstream AW handshake.
- s_awaddr  in  NUM_PORTS*ADDR_W  upstream AW address.
- s_awid  in  NUM_PORTS*ID_W  upstream AW ID.
- s_wvalid/s_wready  in/out  NUM_PORTS  upstream W handshake.
- s_wdata  in  NUM_PORTS*DATA_W  upstream W data.
- s_wstrb  in  NUM_PORTS*DATA_W/8  upstream W strobe.
- s_wlast  in  NUM_PORTS  upstream W last.
- s_bvalid/s_bready  out/in  NUM_PORTS  upstream B handshake.
- s_bid  out  NUM_PORTS*ID_W  upstream B ID.
- s_bresp  out  NUM_PORTS*2  upstream B response.
- m_aw*, m_w*, m_b*: the same fields as the s_ side with every direction inverted; the downstream side.
- out_cnt  out  NUM_PORTS*CNT_W  live outstanding-write count per port.
- err_unexp_b  out  NUM_PORTS  sticky flag: B received while the count was 0.
- err_clr  in  NUM_PORTS  synchronous clear of err_unexp_b per port.

Function
REQ-007 Each port SHALL be fully independent; there is no arbitration or sharing between ports.
REQ-008 AW, W and B channels of every port SHALL each pass through a 2-entry skid buffer.
- States: EMPTY, ONE, TWO.
- Push with no pop: EMPTY->ONE, ONE->TWO.
- Pop with no push: TWO->ONE, ONE->EMPTY.
- Simultaneous push and pop: state unchanged.
REQ-009 Skid buffer input ready SHALL be a registered signal, equal to (state != TWO) for the next cycle; no combinational path from output ready to input ready.
REQ-010 Forward latency SHALL be exactly 1 cycle: a push in cycle N gives output valid in cycle N+1 when the buffer was EMPTY.
REQ-011 Output valid and payload SHALL stay stable until the output handshake completes; entries SHALL leave in FIFO order.
REQ-012 The AW buffer input ready SHALL additionally be forced low while (out_cnt + AW entries held in the skid) >= MAX_OUTSTANDING, so the limit is never exceeded.
REQ-013 out_cnt SHALL update on the downstream handshakes:
- +1 on an m_aw handshake.
- -1 on an m_b handshake.
- Both in the same cycle: unchanged.
REQ-014 An m_b handshake while out_cnt == 0 SHALL:
- leave out_cnt at 0 (no underflow);
- set err_unexp_b next cycle;
- still forward the response.
REQ-015 err_unexp_b SHALL stay set until err_clr is high; set and clear in the same cycle resolves to set.
REQ-016 W data SHALL NOT be gated by the AW count; W beats pass independently of AW.
REQ-017 bresp and bid SHALL be passed unmodified.

Reset
REQ-018 While rst_n is low, every valid output, every ready output, out_cnt and err_unexp_b SHALL be 0, and all skid buffers SHALL be EMPTY.
REQ-019 Readys SHALL rise to 1 on the first rising clk edge after rst_n deasserts.
REQ-020 Reset asserted mid-transfer SHALL discard buffered beats immediately; no partial beat appears after reset.

Verification
REQ-021 Port 0, single AW with addr 0x1000, id 3, m_awready=1 -> m_awvalid high exactly 1 cycle later with addr 0x1000 and id 3; out_cnt[0] = 1 the following cycle.
REQ-022 MAX_OUTSTANDING=8, 8 AWs accepted, no B returned -> s_awready[0]=0 with out_cnt[0]=8; one B returned -> out_cnt=7 and s_awready returns to 1 within 2 cycles.
REQ-023 m_wready held 0, 3 W beats offered -> 2 accepted and s_wready=0 (state TWO); release m_wready -> beats emerge in order with matching wdata/wstrb/wlast.
REQ-024 AW and B handshakes in the same cycle with out_cnt=5 -> out_cnt stays 5.
REQ-025 B on port 1 with out_cnt[1]=0 -> response forwarded, err_unexp_b[1]=1 and held; err_clr[1] pulse -> 0; port 0 is unaffected throughout.
REQ-026 rst_n pulsed low with 2 W beats buffered -> m_wvalid=0 immediately and out_cnt=0; no stale beats after release.
